// File: rtl/lc3b_types.sv
// Shared LC-3b word type plus the constants and types used by the performance
// counter bank and its memory-mapped window.
package lc3b_types;

  typedef logic [15:0] lc3b_word;

  // Selects one of the eight counters in the window.
  typedef logic [2:0] perf_ctr_idx;

  localparam int       PERF_NUM_CTRS  = 8;
  localparam lc3b_word PERF_CTRL_ADDR = 16'hFFF7;
  localparam lc3b_word PERF_CTR_BASE  = 16'hFFF8;

  typedef enum logic {
    PW_IDLE,
    PW_RESP
  } perf_wr_state;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with clear, hold and increment controls.
// Clear beats hold, and hold beats increment.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             hold,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] r_count;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (!hold && inc && (r_count != '1)) begin
      // All-ones is tested before the add, so the sum can never carry out.
      r_count <= r_count + ONE;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/perf_counter_bank.sv
// Eight saturating event counters with a write-side decoder that clears single
// counters, clears all counters, or freezes counting.
module perf_counter_bank
  import lc3b_types::*;
#(
  parameter int       WIDTH     = 16,
  parameter lc3b_word CTRL_ADDR = PERF_CTRL_ADDR,
  parameter lc3b_word CTR_BASE  = PERF_CTR_BASE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             write,
  input  logic [15:0]      address,
  input  logic [15:0]      wdata,
  output logic             write_resp,
  output logic             claimed,
  input  logic             icache_hit,
  input  logic             icache_miss,
  input  logic             dcache_hit,
  input  logic             dcache_miss,
  input  logic             l2_hit,
  input  logic             l2_miss,
  input  logic             br,
  input  logic             br_mispredict,
  output logic [WIDTH-1:0] icache_hit_count,
  output logic [WIDTH-1:0] icache_miss_count,
  output logic [WIDTH-1:0] dcache_hit_count,
  output logic [WIDTH-1:0] dcache_miss_count,
  output logic [WIDTH-1:0] l2_hit_count,
  output logic [WIDTH-1:0] l2_miss_count,
  output logic [WIDTH-1:0] br_count,
  output logic [WIDTH-1:0] br_mispredict_count,
  output logic             frozen
);

  perf_wr_state r_state;
  perf_wr_state w_next_state;
  logic         r_frozen;

  lc3b_word                 w_offset;
  perf_ctr_idx              w_idx;
  logic                     w_in_window;
  logic                     w_is_ctrl;
  logic                     w_act;
  logic                     w_clr_all;
  logic [PERF_NUM_CTRS-1:0] w_clr_one;
  logic [PERF_NUM_CTRS-1:0] w_events;
  logic [WIDTH-1:0]         w_counts [PERF_NUM_CTRS];
  logic                     w_unused;

  // Subtracting the base lets one compare cover the window wherever it sits.
  assign w_offset    = address - CTR_BASE;
  assign w_idx       = w_offset[2:0];
  assign w_in_window = (w_offset[15:3] == '0);
  assign w_is_ctrl   = (address == CTRL_ADDR);
  assign claimed     = write && (w_is_ctrl || w_in_window);

  // Only the first claimed cycle acts; the response cycle is inert.
  assign w_act     = claimed && (r_state == PW_IDLE);
  assign w_clr_all = w_act && w_is_ctrl && wdata[1];
  assign w_unused  = ^wdata[15:2];

  always_comb begin
    // NOTE: default first so no path leaves the signal unassigned (no latch).
    w_clr_one = '0;
    if (w_act && w_in_window) begin
      w_clr_one[w_idx] = 1'b1;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      PW_IDLE: if (claimed) w_next_state = PW_RESP;
      PW_RESP: w_next_state = PW_IDLE;
      default: w_next_state = PW_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= PW_IDLE;
      r_frozen <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_act && w_is_ctrl) begin
        r_frozen <= wdata[0];
      end
    end
  end

  assign write_resp = (r_state == PW_RESP);
  assign frozen     = r_frozen;

  assign w_events = {br_mispredict, br, l2_miss, l2_hit,
                     dcache_miss, dcache_hit, icache_miss, icache_hit};

  for (genvar g = 0; g < PERF_NUM_CTRS; g++) begin : g_ctr
    sat_counter #(.WIDTH(WIDTH)) u_ctr (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (w_clr_all || w_clr_one[g]),
      .hold  (r_frozen),
      .inc   (w_events[g]),
      .count (w_counts[g])
    );
  end

  assign icache_hit_count    = w_counts[0];
  assign icache_miss_count   = w_counts[1];
  assign dcache_hit_count    = w_counts[2];
  assign dcache_miss_count   = w_counts[3];
  assign l2_hit_count        = w_counts[4];
  assign l2_miss_count       = w_counts[5];
  assign br_count            = w_counts[6];
  assign br_mispredict_count = w_counts[7];

endmodule

// File: tb/tb_perf_counter_bank.sv
// Directed bench for perf_counter_bank: counting, saturation, clears, freeze,
// reset mid-handshake and unclaimed writes, against hand-computed values.
module tb_perf_counter_bank;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        write;
  logic [15:0] address;
  logic [15:0] wdata;
  logic        write_resp;
  logic        claimed;
  logic        icache_hit, icache_miss, dcache_hit, dcache_miss;
  logic        l2_hit, l2_miss, br, br_mispredict;
  logic [15:0] cnt [8];
  logic        frozen;

  int n_checks = 0;
  int n_fails  = 0;
  logic [15:0] exp_cnt [8];

  perf_counter_bank dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .write               (write),
    .address             (address),
    .wdata               (wdata),
    .write_resp          (write_resp),
    .claimed             (claimed),
    .icache_hit          (icache_hit),
    .icache_miss         (icache_miss),
    .dcache_hit          (dcache_hit),
    .dcache_miss         (dcache_miss),
    .l2_hit              (l2_hit),
    .l2_miss             (l2_miss),
    .br                  (br),
    .br_mispredict       (br_mispredict),
    .icache_hit_count    (cnt[0]),
    .icache_miss_count   (cnt[1]),
    .dcache_hit_count    (cnt[2]),
    .dcache_miss_count   (cnt[3]),
    .l2_hit_count        (cnt[4]),
    .l2_miss_count       (cnt[5]),
    .br_count            (cnt[6]),
    .br_mispredict_count (cnt[7]),
    .frozen              (frozen)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  task automatic check_counts(input string tag);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("%s.cnt%0d", tag, i), {16'h0, cnt[i]}, {16'h0, exp_cnt[i]});
    end
  endtask

  task automatic set_exp(input logic [15:0] v [8]);
    for (int i = 0; i < 8; i++) exp_cnt[i] = v[i];
  endtask

  // Bit i drives event input i, in counter order.
  task automatic set_events(input logic [7:0] ev);
    {br_mispredict, br, l2_miss, l2_hit, dcache_miss, dcache_hit, icache_miss, icache_hit} = ev;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [7:0] ev, input int n);
    set_events(ev);
    repeat (n) step();
    set_events(8'h00);
  endtask

  // Claimed write with optional events in the same cycle; requester drops
  // write in the cycle it sees write_resp.
  task automatic do_write(input string tag, input logic [15:0] a, input logic [15:0] d,
                          input logic [7:0] ev);
    write = 1'b1; address = a; wdata = d;
    set_events(ev);
    #1;
    check({tag, ".claimed"}, {31'h0, claimed}, 32'h1);
    check({tag, ".resp_pre"}, {31'h0, write_resp}, 32'h0);
    step();
    set_events(8'h00);
    check({tag, ".resp"}, {31'h0, write_resp}, 32'h1);
    write = 1'b0;
    step();
    check({tag, ".resp_off"}, {31'h0, write_resp}, 32'h0);
  endtask

  initial begin
    rst_n = 1'b0; write = 1'b0; address = '0; wdata = '0;
    set_events(8'h00);
    #1;
    set_exp('{default: 16'h0});
    check_counts("reset");
    check("reset.frozen", {31'h0, frozen}, 32'h0);
    check("reset.resp", {31'h0, write_resp}, 32'h0);
    step(); step();
    rst_n = 1'b1;
    step();

    // Five icache_hit cycles.
    pulse(8'h01, 5);
    set_exp('{16'd5, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0});
    check_counts("icache5");

    // br saturation: 65534 cycles short of the ceiling, then past it.
    set_events(8'h40);
    repeat (65534) step();
    check("br.pre_sat", {16'h0, cnt[6]}, 32'h0000FFFE);
    repeat (6) step();
    set_events(8'h00);
    set_exp('{16'd5, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'hFFFF, 16'd0});
    check_counts("br_sat");
    step();
    check("br.sticky", {16'h0, cnt[6]}, 32'h0000FFFF);

    // Clear dcache_hit while it is also pulsing: clear wins.
    pulse(8'h04, 4);
    check("dcache.loaded", {16'h0, cnt[2]}, 32'd4);
    do_write("clr_dcache", 16'hFFFA, 16'h5A5A, 8'h04);
    check_counts("clr_dcache");

    // Freeze set with l2_hit in the same cycle: that event still counts.
    do_write("freeze", 16'hFFF7, 16'h0001, 8'h10);
    check("freeze.frozen", {31'h0, frozen}, 32'h1);
    pulse(8'h20, 10);
    // Unfreeze with l2_hit in the same cycle: that event is dropped.
    do_write("unfreeze", 16'hFFF7, 16'h0000, 8'h10);
    check("unfreeze.frozen", {31'h0, frozen}, 32'h0);
    pulse(8'h20, 3);
    set_exp('{16'd5, 16'd0, 16'd0, 16'd0, 16'd1, 16'd3, 16'hFFFF, 16'd0});
    check_counts("freeze");

    // Clear-all from a fully loaded bank.
    pulse(8'hFF, 2);
    set_exp('{16'd7, 16'd2, 16'd2, 16'd2, 16'd3, 16'd5, 16'hFFFF, 16'd2});
    check_counts("loaded");
    do_write("clr_all", 16'hFFF7, 16'h0002, 8'h00);
    set_exp('{default: 16'h0});
    check_counts("clr_all");
    check("clr_all.frozen", {31'h0, frozen}, 32'h0);

    // Reset dropped while the FSM is in its response cycle.
    pulse(8'hFF, 1);
    write = 1'b1; address = 16'hFFF9; wdata = 16'h0;
    step();
    check("rstmid.resp", {31'h0, write_resp}, 32'h1);
    check("rstmid.cnt0", {16'h0, cnt[0]}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_counts("rstmid");
    check("rstmid.resp_low", {31'h0, write_resp}, 32'h0);
    write = 1'b0;
    #2;
    rst_n = 1'b1;
    step();
    check("rstmid.no_resp", {31'h0, write_resp}, 32'h0);
    // A fresh write must be acknowledged one cycle later, proving IDLE.
    do_write("post_rst", 16'hFFFF, 16'h0, 8'h00);

    // Unclaimed write carrying a clear-all pattern.
    pulse(8'h01, 2);
    write = 1'b1; address = 16'h1234; wdata = 16'h0003;
    #1;
    check("unclaimed.claimed", {31'h0, claimed}, 32'h0);
    step();
    check("unclaimed.resp1", {31'h0, write_resp}, 32'h0);
    step();
    check("unclaimed.resp2", {31'h0, write_resp}, 32'h0);
    write = 1'b0;
    set_exp('{16'd2, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0});
    check_counts("unclaimed");
    check("unclaimed.frozen", {31'h0, frozen}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
